// File: rtl/dmem_pkg.sv
// Shared types and geometry helpers for the data-memory controller.
// Default geometry constants describe the 64-bit x 1024-word configuration.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 1024;

  function automatic int byte_off_w(input int data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 0;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int BYTE_OFF_W = byte_off_w(DEF_DATA_W);
  localparam int IDX_W      = idx_w(DEF_DEPTH);

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: byte-enabled synchronous write, combinational read.
// Contents are never reset; the array is named mem for hierarchical preload.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IW     = IDX_W
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IW-1:0]         i_idx,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_be,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // byte-lane write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = mem[i_idx];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request capture, LATENCY wait-state FSM,
// one-cycle response. Optional macro DMEM_ALIGN_CHECK_EN flags misaligned addresses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  dmem_error
);

  localparam int OFF_W = (DATA_W == DEF_DATA_W) ? BYTE_OFF_W : byte_off_w(DATA_W);
  localparam int IW    = idx_w(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_e              r_state;
  state_e              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_dmem_error;

  logic                w_ready;
  logic                w_accept;
  logic                w_access;
  logic [ADDR_W-1:0]   w_word;
  logic [IW-1:0]       w_idx;
  logic                w_oor;
  logic                w_misalign;
  logic                w_err;
  logic                w_wr_en;
  logic [DATA_W-1:0]   w_rdata;

  assign w_word = r_addr >> OFF_W;
  assign w_idx  = w_word[IW-1:0];
  assign w_oor  = (w_word >= DEPTH_A);

`ifdef DMEM_ALIGN_CHECK_EN
  if (OFF_W > 0) begin : g_align
    assign w_misalign = |r_addr[OFF_W-1:0];
  end else begin : g_no_align
    assign w_misalign = 1'b0;
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err    = w_oor | w_misalign;
  assign w_accept = req_valid & w_ready;
  // rst_n gate keeps a reset landing on the access edge from committing the write
  assign w_wr_en  = w_access & r_we & ~w_err & rst_n;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_WAIT;
        else          w_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (w_access) w_next = ST_RESP;
        else          w_next = ST_WAIT;
      end
      ST_RESP: begin
        if (w_accept) w_next = ST_WAIT;
        else          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // state-decoded controls; a zero count in WAIT is treated as due so it cannot hang
  always_comb begin
    w_ready  = 1'b1;
    w_access = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready  = 1'b1;
        w_access = 1'b0;
      end
      ST_WAIT: begin
        w_ready  = 1'b0;
        w_access = (r_cnt <= CNT_W'(1));
      end
      ST_RESP: begin
        w_ready  = 1'b1;
        w_access = 1'b0;
      end
      default: begin
        w_ready  = 1'b1;
        w_access = 1'b0;
      end
    endcase
  end

  // wait counter and request capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_cnt   <= CNT_W'(LATENCY);
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // response and sticky error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_dmem_error <= 1'b0;
    end else if (w_access) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_rdata  <= (w_err || r_we) ? '0 : w_rdata;
      r_rsp_err    <= w_err;
      r_dmem_error <= r_dmem_error | w_err;
    end else begin
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_idx   (w_idx),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (w_rdata)
  );

  assign req_ready  = w_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign dmem_error = r_dmem_error;

endmodule
